// File: rtl/sitcp_rbcp_pkg.sv
// Shared types and constants for the SiTCP RBCP sequencer/router.
package sitcp_rbcp_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam int SEL_MSB = 31;
    localparam int SEL_LSB = 28;
    localparam int SEL_W   = SEL_MSB - SEL_LSB + 1;
    localparam int OFS_W   = 28;
    localparam int ERR_W   = 8;

    typedef struct packed {
        logic             we;
        logic [SEL_W-1:0] sel;
        logic [OFS_W-1:0] ofs;
        logic [7:0]       wd;
    } rbcp_req_t;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/rbcp_wdog.sv
// Loadable down-counter watchdog; expired flags the cycle the count steps to zero.
module rbcp_wdog (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        en,
    output logic        expired
);
    logic [15:0] cnt;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en && cnt != 16'd0)
            cnt <= cnt - 16'd1;
    end

    // Counting down from 1 (or already idle at 0) means time is up this cycle.
    assign expired = en && !load && (cnt <= 16'd1);
endmodule

// File: rtl/sitcp_rbcp_router.sv
// RBCP transaction sequencer: decodes ADDR[31:28] to a slave window, strobes it,
// waits for its ACK under a watchdog and returns one RBCP_ACK pulse.
module sitcp_rbcp_router
    import sitcp_rbcp_pkg::*;
#(
    parameter int N_SLV   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic                 RBCP_ACT,
    input  logic [31:0]          RBCP_ADDR,
    input  logic                 RBCP_WE,
    input  logic [7:0]           RBCP_WD,
    input  logic                 RBCP_RE,
    output logic                 RBCP_ACK,
    output logic [7:0]           RBCP_RD,
    output logic [OFS_W-1:0]     S_ADDR,
    output logic [7:0]           S_WD,
    output logic [N_SLV-1:0]     S_WE,
    output logic [N_SLV-1:0]     S_RE,
    input  logic [N_SLV-1:0]     S_ACK,
    input  logic [8*N_SLV-1:0]   S_RD,
    output logic                 BUSY,
    output logic [ERR_W-1:0]     ERR_CNT
);
    localparam logic [SEL_W:0] N_SLV_L = 5'(N_SLV);

    state_t           state;
    rbcp_req_t        req;
    logic [SEL_W-1:0] new_sel;
    logic             sel_ok;
    logic [N_SLV-1:0] oh_new;
    logic             ack_sel;
    logic [7:0]       rd_mux;
    logic             wd_expired;

    assign new_sel = RBCP_ADDR[SEL_MSB:SEL_LSB];
    assign sel_ok  = {1'b0, new_sel} < N_SLV_L;
    assign S_ADDR  = req.ofs;
    assign S_WD    = req.wd;

    always_comb begin
        oh_new  = '0;
        ack_sel = 1'b0;
        rd_mux  = 8'h00;
        for (int k = 0; k < N_SLV; k++) begin
            if (new_sel == SEL_W'(k))
                oh_new[k] = 1'b1;
            if (req.sel == SEL_W'(k)) begin
                ack_sel = S_ACK[k];
                rd_mux  = S_RD[8*k +: 8];
            end
        end
    end

    rbcp_wdog u_wdog (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .load     (state == ST_ISSUE),
        .load_val (16'(TIMEOUT)),
        .en       (state == ST_WAIT),
        .expired  (wd_expired)
    );

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state    <= ST_IDLE;
            req      <= '0;
            S_WE     <= '0;
            S_RE     <= '0;
            RBCP_ACK <= 1'b0;
            RBCP_RD  <= 8'h00;
            BUSY     <= 1'b0;
            ERR_CNT  <= '0;
        end else begin
            S_WE     <= '0;
            S_RE     <= '0;
            RBCP_ACK <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (RBCP_ACT && (RBCP_WE || RBCP_RE)) begin
                        if (sel_ok) begin
                            req   <= '{we: RBCP_WE, sel: new_sel,
                                       ofs: RBCP_ADDR[OFS_W-1:0], wd: RBCP_WD};
                            S_WE  <= RBCP_WE ? oh_new : '0;
                            S_RE  <= RBCP_WE ? '0 : oh_new;
                            state <= ST_ISSUE;
                            BUSY  <= 1'b1;
                        end else begin
                            // Unmapped window: withhold ACK so SiTCP flags a bus error.
                            ERR_CNT <= sat_inc(ERR_CNT);
                        end
                    end
                end
                ST_ISSUE: begin
                    if (!RBCP_ACT) begin
                        state <= ST_IDLE;
                        BUSY  <= 1'b0;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!RBCP_ACT) begin
                        state <= ST_IDLE;
                        BUSY  <= 1'b0;
                    end else if (ack_sel) begin
                        // ACK beats a watchdog expiring in the same cycle.
                        RBCP_RD  <= rd_mux;
                        RBCP_ACK <= 1'b1;
                        state    <= ST_RESP;
                    end else if (wd_expired) begin
                        ERR_CNT <= sat_inc(ERR_CNT);
                        state   <= ST_IDLE;
                        BUSY    <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/sitcp_rbcp_router.md
# sitcp_rbcp_router

Sequencer and address router for the SiTCP RBCP local bus. Accepts one RBCP write or read transaction at a time and routes it to one of `N_SLV` register slaves by address window. It also guards the transaction with a watchdog, so an unmapped address or a silent slave never hangs the UDP register path. It sits between the SiTCP core's `RBCP_*` user port and the design's register banks, all on the SiTCP user clock.

## Interface
- `N_SLV`, 4: number of slave windows, 1..16.
- `TIMEOUT`, 255: cycles to wait for a slave ACK before abort, 2..65535.
- `CLK` in 1: SiTCP user clock (`USRCLK` domain, 125 MHz). This is the only clock.
- `RSTn` in 1: reset, asynchronous, active-low.
- `RBCP_ACT` in 1: RBCP transaction active, from SiTCP.
- `RBCP_ADDR` in 32: byte address. `[31:28]` selects the window; `[27:0]` is the offset.
- `RBCP_WE` in 1: one-cycle write strobe.
- `RBCP_WD` in 8: write data.
- `RBCP_RE` in 1: one-cycle read strobe.
- `RBCP_ACK` out 1: one-cycle access acknowledge, to SiTCP.
- `RBCP_RD` out 8: read data, valid while `RBCP_ACK`=1.
- `S_ADDR` out 28: offset, shared by all slaves.
- `S_WD` out 8: write data, shared by all slaves.
- `S_WE` out N_SLV: per-slave one-cycle write strobe.
- `S_RE` out N_SLV: per-slave one-cycle read strobe.
- `S_ACK` in N_SLV: per-slave acknowledge, one cycle or longer.
- `S_RD` in 8*N_SLV: per-slave read data. Slave k drives `[8k+7:8k]`, valid with its ACK.
- `BUSY` out 1: a transaction is in flight (state is not IDLE).
- `ERR_CNT` out 8: count of aborted transactions, saturating.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT and RESP.
- IDLE, on `RBCP_WE|RBCP_RE` with `RBCP_ACT`=1:
  - Latch the address, the data, the operation (WE wins if both strobes are set) and `sel=ADDR[31:28]`.
  - If `sel < N_SLV`, go to ISSUE.
  - Otherwise increment `ERR_CNT` and stay in IDLE. No slave strobe and no ACK are issued, so SiTCP reports a bus error to the host.
- ISSUE: assert `S_WE[sel]` or `S_RE[sel]` for exactly one cycle, load the watchdog with `TIMEOUT`, then go to WAIT.
- WAIT:
  - On `S_ACK[sel]`, register `S_RD[sel]` into `RBCP_RD` (writes also register the slave value) and go to RESP.
  - ACKs from non-selected slaves are ignored.
  - When the watchdog reaches 0, increment `ERR_CNT` and go to IDLE with no ACK.
- RESP: `RBCP_ACK`=1 for one cycle, then go to IDLE.
- If `RBCP_ACT` falls while in ISSUE or WAIT: abort to IDLE on the next cycle. Issue no ACK and do not increment `ERR_CNT`. A late `S_ACK` is ignored.
- Strobes that arrive outside IDLE are ignored.
- `S_ADDR` and `S_WD` hold the latched values from ISSUE until the next accepted transaction; they do not return to 0.
- `ERR_CNT` saturates at 255 and is cleared only by reset.
- Reset values:
  - All outputs 0, state IDLE.
  - `RBCP_RD`=0x00, `ERR_CNT`=0.
  - Watchdog at 0.

## Timing
- Strobe sampled at cycle T:
  - `S_*E` is high at T+1.
  - The earliest `S_ACK` that counts is sampled at T+2, the first WAIT cycle.
  - `RBCP_ACK` follows one cycle after the sampled `S_ACK`; the minimum total is T+3.
- An `S_ACK` asserted during ISSUE (T+1) is not sampled. Slaves must assert ACK in the cycle after their strobe or later.
- Watchdog: WAIT is entered at T+2. With no ACK, the abort to IDLE happens at T+2+TIMEOUT.
- An ACK arriving in the same cycle the watchdog reaches 0 wins: go to RESP and do not count an error.
- Back-to-back transactions: a new strobe is accepted in the cycle after RESP.
- All outputs are registered. There is no combinational path from `S_ACK` to `RBCP_ACK`.

## Structure
- Package `sitcp_rbcp_pkg`:
  - State encoding: IDLE=0, ISSUE=1, WAIT=2, RESP=3.
  - `SEL_MSB`=31 and `SEL_LSB`=28.
  - Offset width 28.
  - Error-counter width 8.
- Sub-module `rbcp_wdog`: a loadable down-counter.
  - Inputs: `load`, `load_val[15:0]`, `en`.
  - Output: `expired`.
  - It is reused for other bus timeouts.
- Slave-select muxing stays in the top-level module.

## Test plan
- Read at `0x1000_0010`; slave 1 ACKs 3 cycles after its strobe with RD=0xA5:
  - `S_RE`=4'b0010 for one cycle and `S_ADDR`=0x000_0010.
  - `RBCP_ACK` one cycle after `S_ACK`, with `RBCP_RD`=0xA5.
  - `ERR_CNT`=0.
- Write 0x3C at `0x0000_0004`; slave 0 ACKs:
  - `S_WE`=4'b0001 for one cycle and `S_WD`=0x3C.
  - One `RBCP_ACK` pulse.
  - No `S_RE` activity.
- Read at `0x5000_0000` with N_SLV=4:
  - No `S_*E` pulses and no `RBCP_ACK`.
  - `ERR_CNT`=1 and `BUSY` stays 0.
- Read at slave 2; slave 2 never ACKs; slave 3 ACKs spuriously; TIMEOUT=16:
  - Spurious ACK ignored.
  - Return to IDLE 16 cycles after WAIT entry, with no ACK and `ERR_CNT`+1.
  - 300 such reads leave `ERR_CNT`=255.
- Two cases mid-transaction:
  - `RBCP_ACT` dropped during WAIT: abort with no ACK, `ERR_CNT` unchanged, and a later `S_ACK` ignored.
  - `RSTn` pulsed low during WAIT: every output reads 0 asynchronously.
- Back-to-back: a write then a read with strobes 1 cycle after `RBCP_ACK`:
  - Both are served in order.
  - A strobe injected during WAIT is ignored.
